// File: rtl/logic_selftest_ctrl_if.sv
// Bus between the logic self-test controller and the datapath under test.
// The inject port exists only when SELFTEST_INJECT_EN is defined.
interface logic_selftest_ctrl_if;
  logic       start;
  logic       abort;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       e;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_fail;
  logic       fail_valid;
`ifdef SELFTEST_INJECT_EN
  logic       inject;
`endif

  modport master (
`ifdef SELFTEST_INJECT_EN
    input  inject,
`endif
    input  start,
    input  abort,
    input  d,
    input  e,
    output a,
    output b,
    output c,
    output busy,
    output done,
    output pass,
    output err_count,
    output first_fail,
    output fail_valid
  );

  modport slave (
`ifdef SELFTEST_INJECT_EN
    output inject,
`endif
    output start,
    output abort,
    output d,
    output e,
    input  a,
    input  b,
    input  c,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  first_fail,
    input  fail_valid
  );
endinterface

// File: rtl/logic_selftest_ctrl.sv
// Walks {a,b,c} through all 8 vectors and checks d=(a&b)|~c, e=~c.
// Optional SELFTEST_INJECT_EN adds inject: flips expected d of vector 0.
module logic_selftest_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic            clk,
  input logic            rst_n,
  logic_selftest_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] v_q, v_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] abc_q, abc_d;
  logic [3:0] err_q, err_d;
  logic [2:0] ff_q, ff_d;
  logic       fv_q, fv_d;
  logic       pass_q, pass_d;
  logic       done_q, done_d;

  logic       busy;
  logic       launch;
  logic       flip;
  logic       exp_d;
  logic       exp_e;
  logic       mis;

  assign busy = (state_q == APPLY) ||
                (state_q == SETTLE) ||
                (state_q == SAMPLE);

  assign launch = (state_q == IDLE) &&
                  bus.start && !bus.abort;

`ifdef SELFTEST_INJECT_EN
  logic inj_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_q <= 1'b0;
    end else if (launch) begin
      inj_q <= bus.inject;
    end
  end

  assign flip = inj_q && (abc_q == 3'b000);
`else
  assign flip = 1'b0;
`endif

  assign exp_d = ((abc_q[2] & abc_q[1]) | ~abc_q[0]) ^ flip;
  assign exp_e = ~abc_q[0];
  assign mis   = (bus.d != exp_d) || (bus.e != exp_e);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v_q     <= 3'd0;
      cnt_q   <= 4'd0;
      abc_q   <= 3'd0;
      err_q   <= 4'd0;
      ff_q    <= 3'd0;
      fv_q    <= 1'b0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      abc_q   <= abc_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    abc_d   = abc_q;
    err_d   = err_q;
    ff_d    = ff_q;
    fv_d    = fv_q;
    pass_d  = pass_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        abc_d = 3'd0;
        if (launch) begin
          state_d = APPLY;
          v_d     = 3'd0;
          err_d   = 4'd0;
          fv_d    = 1'b0;
          pass_d  = 1'b0;
        end
      end
      APPLY: begin
        state_d = SETTLE;
        cnt_d   = CNT_LOAD;
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = 4'(cnt_q - 4'd1);
        end
      end
      SAMPLE: begin
        if (mis) begin
          err_d = 4'(err_q + 4'd1);
          if (!fv_q) begin
            ff_d = v_q;
            fv_d = 1'b1;
          end
        end
        // Pass reflects the final vector's sample too
        if (v_q == 3'd7) begin
          state_d = DONE;
          abc_d   = 3'd0;
          pass_d  = (err_d == 4'd0);
        end else begin
          state_d = APPLY;
          v_d     = 3'(v_q + 3'd1);
          abc_d   = 3'(v_q + 3'd1);
        end
      end
      DONE: begin
        state_d = IDLE;
        abc_d   = 3'd0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        abc_d   = 3'd0;
      end
    endcase

    // Abort discards the pending sample and keeps partial results
    if (busy && bus.abort) begin
      state_d = IDLE;
      v_d     = v_q;
      cnt_d   = cnt_q;
      abc_d   = 3'd0;
      err_d   = err_q;
      ff_d    = ff_q;
      fv_d    = fv_q;
      pass_d  = 1'b0;
    end
  end

  assign bus.a          = abc_q[2];
  assign bus.b          = abc_q[1];
  assign bus.c          = abc_q[0];
  assign bus.busy       = busy;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = ff_q;
  assign bus.fail_valid = fv_q;

endmodule

// File: doc/logic_selftest_ctrl.md
LOGIC_SELFTEST_CTRL -- requirements
Module: logic_selftest_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, range 1..15: cycles vector held before sampling.
REQ-002 Clk  input  1  sole clock, rising-edge.
REQ-003 Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Start  input  1  level; begin test run when sampled high in IDLE.
REQ-005 Abort  input  1  level; terminate run in progress.
REQ-006 A, B, C  output  1 each  registered stimulus driven to the logic datapath.
REQ-007 D, E  input  1 each  datapath results under test.
REQ-008 Busy  output  1  high while a run is in progress.
REQ-009 Done  output  1  one-cycle pulse at run completion.
REQ-010 Pass  output  1  held; 1 = last completed run had zero mismatches.
REQ-011 ErrCount  output  4  mismatching vectors in current/last run, 0..8.
REQ-012 FirstFail  output  3  index {A,B,C} of first mismatching vector.
REQ-013 FailValid  output  1  FirstFail holds a valid index.

Function
REQ-014 FSM states SHALL be IDLE, APPLY, SETTLE, SAMPLE, DONE; one-hot or binary at implementer's choice.
REQ-015 IDLE->APPLY when Start=1 and Abort=0; on that edge vector index V, ErrCount, FailValid, Pass SHALL clear to 0.
REQ-016 APPLY: {A,B,C} registered to V; next state SETTLE with settle counter loaded to SETTLE_CYCLES-1.
REQ-017 SETTLE: counter decrements each cycle; exit to SAMPLE on cycle counter reads 0 (exactly SETTLE_CYCLES cycles in SETTLE).
REQ-018 SAMPLE: expected D = (A AND B) OR NOT C, expected E = NOT C, computed from registered A,B,C; mismatch on D or E increments ErrCount by 1.
REQ-019 First mismatch of a run SHALL load FirstFail=V and set FailValid=1; later mismatches SHALL not alter FirstFail.
REQ-020 SAMPLE->APPLY with V+1 when V<7; SAMPLE->DONE when V=7; V SHALL never wrap within a run.
REQ-021 DONE: Done=1 for exactly one cycle, Pass=(ErrCount==0) updated on entry, next state IDLE unconditionally.
REQ-022 Done SHALL assert exactly 8*(SETTLE_CYCLES+2)+1 cycles after the edge sampling Start.
REQ-023 Busy SHALL be 1 in APPLY, SETTLE, SAMPLE; 0 in IDLE and DONE.
REQ-024 {A,B,C} SHALL be 3'b000 in IDLE and DONE.
REQ-025 Start while Busy=1 SHALL be ignored; Start held high after DONE SHALL start a new run from IDLE.
REQ-026 Abort=1 in APPLY/SETTLE/SAMPLE SHALL force IDLE next edge, no Done pulse, Pass=0; ErrCount/FirstFail/FailValid retain partial values.
REQ-027 Start and Abort both high in IDLE: Abort wins, stay IDLE.
REQ-028 ErrCount SHALL not exceed 8 (4-bit, no overflow possible).

Reset
REQ-029 Rst_n=0 SHALL immediately force IDLE, V=0, counter=0, A=B=C=0, Busy=0, Done=0, Pass=0, ErrCount=0, FirstFail=0, FailValid=0.
REQ-030 Rst_n asserted mid-run SHALL abandon the run with no Done pulse; first Start after release begins fresh at V=0.

Configuration
REQ-031 Macro SELFTEST_INJECT_EN defined: extra input Inject (1b); Inject sampled with Start; if 1, expected D for vector 3'b000 inverted for that run.
REQ-032 SELFTEST_INJECT_EN undefined: no Inject port; expected values per REQ-018 only.

Verification (SETTLE_CYCLES=2, correct datapath unless stated)
REQ-033 Reset then Start pulse -> vectors 0..7 in order, 4 cycles each, Done at cycle 33, Pass=1, ErrCount=0, FailValid=0.
REQ-034 Datapath E stuck at 0 -> mismatches at V=0,2,4,6; ErrCount=4, FirstFail=0, FailValid=1, Pass=0.
REQ-035 Abort asserted while V=3 in SETTLE -> IDLE next edge, Busy=0, no Done, Pass=0, A=B=C=0.
REQ-036 Start re-pulsed mid-run at V=5 -> ignored, Done still at cycle 33; Rst_n low at V=2 -> all outputs zero immediately, no Done.
REQ-037 With SELFTEST_INJECT_EN, Inject=1 at Start -> ErrCount=1, FirstFail=0, Pass=0; Inject=0 -> Pass=1.
